fib_stream: RTL
===============

# fib_stream

Parametrised iterative generalised-Fibonacci engine: the next generation of the single-shot `main` fib core. It evaluates `f(n, a, b) = (n == 0) ? a : f(n-1, a+b, a)` at one iteration per cycle, with configurable data and count widths. It adds optional modular arithmetic, a sticky overflow flag and an optional per-term stream output with backpressure. It sits behind the host load interface, which provides `r_enable` and the init values and collects `w_enable` and `result`.

## Interface
- `WIDTH`, 32: width of `a`, `b`, modulus, `result` and `term_data`.
- `CNT_WIDTH`, 32: width of `init_n`.
- `STREAM`, 0: 1 enables the `term_*` output and its backpressure. 0 ties `term_valid` to 0 and ignores `term_ready`.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r_enable`  in  1  load request; accepted only when `busy == 0`.
- `init_n`  in  CNT_WIDTH  iteration count.
- `init_a`  in  WIDTH  initial `a`.
- `init_b`  in  WIDTH  initial `b`.
- `mod_en`  in  1  enable modular reduction; latched at acceptance.
- `modulus`  in  WIDTH  modulus; latched at acceptance. A value of 0 means plain 2^WIDTH wrap.
- `busy`  out  1  high from the cycle after acceptance until `w_enable`.
- `w_enable`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  final `a`; holds its value until the next completion.
- `overflow`  out  1  sticky carry-out flag for the current or last job.
- `term_valid`  out  1  stream term available.
- `term_ready`  in  1  stream consumer ready.
- `term_data`  out  WIDTH  current `a` before each step.

## Operation
- Reset values: state IDLE, `busy` 0, `w_enable` 0, `result` 0, `overflow` 0, `term_valid` 0. Reset wins over every other event, including mid-run; a job in progress is discarded with no `w_enable`.
- There are two states, IDLE and RUN.
- IDLE:
  - On `r_enable`, load `n`, `a`, `b`, `mod_en` and `modulus`, clear `overflow`, and go to RUN.
  - `r_enable` in RUN is ignored. It is neither queued nor restarts the job.
- RUN, each cycle:
  - If `n == 0`: `result <= a`, `w_enable <= 1` for one cycle, go to IDLE.
  - Else, if the step fires: `n <= n-1`, `a <= s`, `b <= a`.
  - The step fires when `STREAM == 0`, or when `term_valid && term_ready`.
- Sum `s`, computed from a WIDTH+1-bit `a + b`:
  - If `mod_en` is set and `modulus != 0`: when the sum is ≥ `modulus`, `s` is the sum minus `modulus`, otherwise the sum. Operands are required to be < `modulus`; results for out-of-range operands are not checked.
  - Otherwise `s` is the low WIDTH bits, and a set carry bit sets `overflow`, which stays set until the next acceptance.
- Stream (`STREAM == 1`):
  - `term_valid = (state == RUN) && (n != 0)`, `term_data = a`.
  - `term_data` is stable while `term_valid && !term_ready`.
  - The number of terms emitted per job is exactly `n`.

## Timing
- Acceptance edge E0 is the edge on which IDLE samples `r_enable == 1`.
- Without backpressure, step k occurs at edge Ek (k = 1..n). Edge E(n+1) registers `result` and `w_enable`, so `w_enable` is high in the cycle after E(n+1).
- Total latency is n+1 cycles after acceptance. Each cycle of `term_ready == 0` while `term_valid` is high adds one cycle.
- `busy` is high from E0 through the edge that asserts `w_enable`. It is low in the `w_enable` cycle, so `r_enable` in that cycle is accepted; back-to-back jobs have no gap.
- `overflow` is valid with `w_enable` and is held until the next acceptance.
- `n == 0`: no steps and no terms; `result = init_a`, `w_enable` one cycle after acceptance.
- Maximum `n` (all ones) is counted down without wrap; `n` never underflows.

## Test plan
- `n=0, a=1, b=0` -> `w_enable` in the 2nd cycle after the `r_enable` cycle, `result=1`, `overflow=0`.
- `WIDTH=32, n=10, a=1, b=0` -> `result=89` exactly 11 cycles after acceptance; then `r_enable` in the `w_enable` cycle with `n=1` -> `result=1`.
- `WIDTH=8, n=12, a=1, b=0` -> `result=233`, `overflow=0`; `n=13` -> `result=121`, `overflow=1`.
- `mod_en=1, modulus=7, n=10, a=1, b=0` -> `result=5`, `overflow=0`; `modulus=0` -> `result=89`.
- `STREAM=1, n=3, a=1, b=0`, `term_ready` low for 4 cycles then high -> `term_data` holds 1 while stalled, then emits 1, 1, 2; `result=3` with `w_enable` 4 cycles later than the unstalled case.
- `r_enable` pulsed mid-run with different inits -> ignored, original result delivered. `rst` mid-run -> all outputs return to reset values, no `w_enable`, and a new job runs normally.

Source files
------------

// File: rtl/fib_stream.sv
// Iterative generalised-Fibonacci engine: f(n,a,b) = n==0 ? a : f(n-1, a+b, a),
// one step per cycle, with optional modular reduction, sticky overflow and a per-term stream.
module fib_stream #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32,
    parameter int STREAM    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r_enable,
    input  logic [CNT_WIDTH-1:0] init_n,
    input  logic [WIDTH-1:0]     init_a,
    input  logic [WIDTH-1:0]     init_b,
    input  logic                 mod_en,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 w_enable,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow,
    output logic                 term_valid,
    input  logic                 term_ready,
    output logic [WIDTH-1:0]     term_data
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] N_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] N_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     W_ZERO = {WIDTH{1'b0}};

    state_t               state_r,    state_s;
    logic [CNT_WIDTH-1:0] n_r,        n_s;
    logic [WIDTH-1:0]     a_r,        a_s;
    logic [WIDTH-1:0]     b_r,        b_s;
    logic                 mod_en_r,   mod_en_s;
    logic [WIDTH-1:0]     modulus_r,  modulus_s;
    logic [WIDTH-1:0]     result_r,   result_s;
    logic                 w_enable_r, w_enable_s;
    logic                 overflow_r, overflow_s;
    logic                 busy_r,     busy_s;

    logic                 mod_active_s;
    logic [WIDTH:0]       step_sum_s;
    logic                 term_valid_s;
    logic                 step_fire_s;

    // Returns {carry, sum}; in modular mode the carry is always zero and the sum is reduced once.
    function automatic logic [WIDTH:0] add_step(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             mod_on,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] sum;
        logic [WIDTH:0] red;
        sum = {1'b0, x} + {1'b0, y};
        red = sum - {1'b0, m};
        if (mod_on) begin
            if (sum >= {1'b0, m}) begin
                add_step = {1'b0, red[WIDTH-1:0]};
            end else begin
                add_step = {1'b0, sum[WIDTH-1:0]};
            end
        end else begin
            add_step = sum;
        end
    endfunction

    assign mod_active_s = mod_en_r && (modulus_r != W_ZERO);
    assign step_sum_s   = add_step(a_r, b_r, mod_active_s, modulus_r);
    assign term_valid_s = (STREAM != 0) && (state_r == RUN) && (n_r != N_ZERO);
    assign step_fire_s  = (STREAM == 0) ? 1'b1 : (term_valid_s && term_ready);

    assign busy       = busy_r;
    assign w_enable   = w_enable_r;
    assign result     = result_r;
    assign overflow   = overflow_r;
    assign term_valid = term_valid_s;
    assign term_data  = a_r;

    // Next-state and datapath update for the IDLE/RUN controller.
    always_comb begin
        state_s    = state_r;
        n_s        = n_r;
        a_s        = a_r;
        b_s        = b_r;
        mod_en_s   = mod_en_r;
        modulus_s  = modulus_r;
        result_s   = result_r;
        w_enable_s = 1'b0;
        overflow_s = overflow_r;
        busy_s     = busy_r;
        case (state_r)
            IDLE: begin
                if (r_enable) begin
                    n_s        = init_n;
                    a_s        = init_a;
                    b_s        = init_b;
                    mod_en_s   = mod_en;
                    modulus_s  = modulus;
                    overflow_s = 1'b0;
                    busy_s     = 1'b1;
                    state_s    = RUN;
                end else begin
                    busy_s     = 1'b0;
                end
            end
            RUN: begin
                if (n_r == N_ZERO) begin
                    result_s   = a_r;
                    w_enable_s = 1'b1;
                    busy_s     = 1'b0;
                    state_s    = IDLE;
                end else if (step_fire_s) begin
                    n_s = n_r - N_ONE;
                    a_s = step_sum_s[WIDTH-1:0];
                    b_s = a_r;
                    if (step_sum_s[WIDTH]) begin
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = overflow_r;
                    end
                end else begin
                    n_s = n_r;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            n_r        <= N_ZERO;
            a_r        <= W_ZERO;
            b_r        <= W_ZERO;
            mod_en_r   <= 1'b0;
            modulus_r  <= W_ZERO;
            result_r   <= W_ZERO;
            w_enable_r <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            n_r        <= n_s;
            a_r        <= a_s;
            b_r        <= b_s;
            mod_en_r   <= mod_en_s;
            modulus_r  <= modulus_s;
            result_r   <= result_s;
            w_enable_r <= w_enable_s;
            overflow_r <= overflow_s;
            busy_r     <= busy_s;
        end
    end

endmodule
